// File: rtl/edge_detect_multi_pkg.sv
// Shared edge-mode encodings and the mode decode used by every channel.
package ox_edge_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t EDGE_OFF  = 2'b00;
  localparam mode_t EDGE_RISE = 2'b01;
  localparam mode_t EDGE_FALL = 2'b10;
  localparam mode_t EDGE_BOTH = 2'b11;

  function automatic logic edge_hit(input mode_t m, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (m)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_detect_multi_chan.sv
// One channel: input synchroniser, glitch filter and registered edge pulse.
module edge_chan
  import ox_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  din,
  input  mode_t mode,
  output logic  level,
  output logic  pulse
);

  logic s;
  logic level_q;
  logic level_d;
  logic pulse_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  generate
    if (FILT_CYCLES == 0) begin : g_nofilt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= s;
      end
    end else begin : g_filt
      localparam int unsigned CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES + 1) : 1;
      logic [CW-1:0] cnt;
      // A single matching cycle discards any accumulated mismatch count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt     <= '0;
          level_q <= 1'b0;
        end else if (s == level_q) begin
          cnt <= '0;
        end else if (cnt == CW'(FILT_CYCLES - 1)) begin
          cnt     <= '0;
          level_q <= s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_d <= level_q;
      pulse_q <= edge_hit(mode, level_q & ~level_d, ~level_q & level_d);
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel detectors plus sticky pending flags and irq.
module edge_detect_multi
  import ox_edge_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   din,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   pend,
  output logic              irq
);

  logic [N_CH-1:0] pend_q;
  logic [N_CH-1:0] pend_next;
  logic            irq_q;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
      ) u_chan (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din[i]),
        .mode (mode_t'(mode[2*i +: 2])),
        .level(level[i]),
        .pulse(pulse[i])
      );
    end
  endgenerate

  // A new event wins over a simultaneous clear so no event is lost.
  always_comb begin
    pend_next = '0;
    pend_next = (pend_q & ~clr) | pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_next;
      irq_q  <= |pend_next;
    end
  end

  assign pend = pend_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench: default-parameter DUT plus a SYNC_STAGES=0/FILT_CYCLES=0 DUT.
module tb_edge_detect_multi;

  typedef struct {
    int         cyc;
    logic [3:0] p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din, clr, level, pulse, pend;
  logic [7:0] mode;
  logic       irq;
  logic [3:0] din2, clr2, level2, pulse2, pend2;
  logic [7:0] mode2;
  logic       irq2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_detect_multi #(.N_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .level(level), .pulse(pulse), .pend(pend), .irq(irq)
  );

  edge_detect_multi #(.N_CH(4), .SYNC_STAGES(0), .FILT_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .mode(mode2), .clr(clr2),
    .level(level2), .pulse(pulse2), .pend(pend2), .irq(irq2)
  );

  // Monitor: every nonzero pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pulse_missing dut cyc %0d: got none, expected %h at cyc %0d", cyc, q1[0].p, q1[0].cyc);
        void'(q1.pop_front());
      end
      if (pulse != 4'h0) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected dut cyc %0d: got %h, expected none", cyc, pulse);
        end else begin
          e = q1.pop_front();
          if (e.cyc != cyc || e.p != pulse) begin
            errors++;
            $display("FAIL pulse dut: got %h at cyc %0d, expected %h at cyc %0d", pulse, cyc, e.p, e.cyc);
          end
        end
      end
      if (q2.size() > 0 && q2[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pulse_missing dut2 cyc %0d: got none, expected %h at cyc %0d", cyc, q2[0].p, q2[0].cyc);
        void'(q2.pop_front());
      end
      if (pulse2 != 4'h0) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected dut2 cyc %0d: got %h, expected none", cyc, pulse2);
        end else begin
          e = q2.pop_front();
          if (e.cyc != cyc || e.p != pulse2) begin
            errors++;
            $display("FAIL pulse dut2: got %h at cyc %0d, expected %h at cyc %0d", pulse2, cyc, e.p, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push1(input int at, input logic [3:0] m);
    exp_t e;
    e.cyc = at; e.p = m;
    q1.push_back(e);
  endtask

  task automatic push2(input int at, input logic [3:0] m);
    exp_t e;
    e.cyc = at; e.p = m;
    q2.push_back(e);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; din = 4'hF; mode = 8'h55; clr = 4'h0;
    din2 = 4'h0; mode2 = 8'h00; clr2 = 4'h0;

    // 1: reset state, then release with din high -> rise on all channels
    tick(3);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_pulse", 32'(pulse), 32'h0);
    chk("reset_pend", 32'(pend), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    c = cyc; rst_n = 1'b1;
    push1(c + 6, 4'hF);
    wait_to(c + 6);
    chk("pend_before_set", 32'(pend), 32'h0);
    wait_to(c + 7);
    chk("pend_after_pulse", 32'(pend), 32'hF);
    chk("irq_after_pulse", 32'(irq), 32'h1);
    din = 4'h0;
    tick(10);
    chk("level_fell_no_pulse", 32'(level), 32'h0);
    clr = 4'hF; tick(1); clr = 4'h0;
    chk("pend_cleared", 32'(pend), 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);

    // 2: glitch rejection, then 3-cycle pulse with rise-only and both modes
    mode = 8'h01;
    din = 4'h1; tick(2); din = 4'h0; tick(10);
    chk("glitch_level", 32'(level), 32'h0);
    c = cyc; din = 4'h1; push1(c + 6, 4'h1);
    tick(3); din = 4'h0; tick(12);
    chk("rise_only_level", 32'(level), 32'h0);
    mode = 8'h03;
    c = cyc; din = 4'h1; push1(c + 6, 4'h1); push1(c + 9, 4'h1);
    tick(3); din = 4'h0; tick(12);
    clr = 4'hF; tick(1); clr = 4'h0;

    // 3: mixed per-channel modes
    mode = 8'hE4;
    c = cyc; din = 4'hF; push1(c + 6, 4'hA);
    tick(10);
    chk("mixed_level_high", 32'(level), 32'hF);
    c = cyc; din = 4'h0; push1(c + 6, 4'hC);
    tick(10);
    chk("mixed_level_low", 32'(level), 32'h0);
    chk("mixed_pend", 32'(pend), 32'hE);
    clr = 4'hF; tick(1); clr = 4'h0;

    // 4: clear coinciding with a new pulse must keep pend set
    mode = 8'h10;
    c = cyc; din = 4'h4; push1(c + 6, 4'h4);
    wait_to(c + 7);
    chk("pend2_set", 32'(pend), 32'h4);
    din = 4'h0; tick(10);
    c = cyc; din = 4'h4; push1(c + 6, 4'h4);
    wait_to(c + 6);
    clr = 4'h4; tick(1); clr = 4'h0;
    chk("pend_setclr_keeps", 32'(pend), 32'h4);
    clr = 4'h4; tick(1); clr = 4'h0;
    chk("pend_clr_alone", 32'(pend), 32'h0);
    chk("irq_clr_alone", 32'(irq), 32'h0);

    // 5: async reset mid-filter (ch0 cnt=2, ch2 level high)
    mode = 8'h01;
    c = cyc; din = 4'h5;
    wait_to(c + 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_pulse", 32'(pulse), 32'h0);
    chk("midrst_pend", 32'(pend), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    din = 4'h0;
    tick(2); rst_n = 1'b1; tick(12);
    chk("post_rst_level", 32'(level), 32'h0);

    // 6: no sync, no filter: toggles every 2 cycles each yield a pulse
    mode2 = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      c = cyc; din2 = din2 ^ 4'h1; push2(c + 2, 4'h1);
      tick(2);
    end
    tick(5);
    chk("dut2_level", 32'(level2), 32'h0);
    chk("dut2_pend", 32'(pend2), 32'h1);

    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("q2_drained", 32'(q2.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
